red_pitaya_limit_block: RTL and testbench

RED_PITAYA_LIMIT_BLOCK -- requirements
Module: red_pitaya_limit

---
 rtl/red_pitaya_limit_block.sv | 147 ++++++++++++++
 tb/tb_red_pitaya_limit_block.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_limit_block.sv
// Dual-channel DAC limiter: clamps each signed channel to a bus-programmable
// [min,max] window and reports railed flags plus the window midpoint.
module red_pitaya_limit_block #(
  parameter int DW = 14
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] dat_a_i,
  input  logic [DW-1:0] dat_b_i,
  output logic [DW-1:0] dat_a_o,
  output logic [DW-1:0] dat_b_o,
  output logic [1:0]    dat_a_railed_o,
  output logic [1:0]    dat_b_railed_o,
  output logic [DW-1:0] center_a_o,
  output logic [DW-1:0] center_b_o,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack
);

  localparam logic signed [DW-1:0] MIN_RST = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_RST = {1'b0, {(DW-1){1'b1}}};

  logic signed [DW-1:0] in_w  [2];
  logic signed [DW-1:0] min_q [2];
  logic signed [DW-1:0] min_d [2];
  logic signed [DW-1:0] max_q [2];
  logic signed [DW-1:0] max_d [2];
  logic [31:0]          rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic [1:0]           railed_w [2];
  logic [DW-1:0]        center_w [2];
  logic                 unused_bits;

  assign unused_bits = ^{sys_addr[31:8], sys_wdata[31:DW]};

  always_comb begin
    in_w[0] = $signed(dat_a_i);
    in_w[1] = $signed(dat_b_i);
  end

  // Per-channel clamp, flags and midpoint, all registered.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [DW-1:0] dat_q, dat_d;
    logic [1:0]           railed_q, railed_d;
    logic signed [DW-1:0] center_q, center_d;
    logic signed [DW:0]   sum_w;

    always_comb begin
      sum_w       = {min_q[gi][DW-1], min_q[gi]} + {max_q[gi][DW-1], max_q[gi]};
      // Dropping the LSB of the widened sum is an arithmetic shift toward -inf.
      center_d    = sum_w[DW:1];
      railed_d[0] = (in_w[gi] <= min_q[gi]);
      railed_d[1] = (in_w[gi] >= max_q[gi]) &&
                    ((in_w[gi] > min_q[gi]) || (min_q[gi] > max_q[gi]));
      if (railed_d[0]) begin
        dat_d = min_q[gi];
      end else if (in_w[gi] >= max_q[gi]) begin
        dat_d = max_q[gi];
      end else begin
        dat_d = in_w[gi];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dat_q    <= '0;
        railed_q <= 2'b00;
        center_q <= '0;
      end else begin
        dat_q    <= dat_d;
        railed_q <= railed_d;
        center_q <= center_d;
      end
    end
  end

  assign dat_a_o        = g_ch[0].dat_q;
  assign dat_b_o        = g_ch[1].dat_q;
  assign dat_a_railed_o = g_ch[0].railed_q;
  assign dat_b_railed_o = g_ch[1].railed_q;
  assign center_a_o     = g_ch[0].center_q;
  assign center_b_o     = g_ch[1].center_q;

  always_comb begin
    railed_w[0] = g_ch[0].railed_q;
    railed_w[1] = g_ch[1].railed_q;
    center_w[0] = g_ch[0].center_q;
    center_w[1] = g_ch[1].center_q;
  end

  always_comb begin
    min_d[0] = min_q[0];
    min_d[1] = min_q[1];
    max_d[0] = max_q[0];
    max_d[1] = max_q[1];
    ack_d    = sys_wen | sys_ren;
    rdata_d  = '0;
    if (sys_wen) begin
      case (sys_addr[7:0])
        8'h08:   min_d[0] = $signed(sys_wdata[DW-1:0]);
        8'h0C:   max_d[0] = $signed(sys_wdata[DW-1:0]);
        8'h10:   min_d[1] = $signed(sys_wdata[DW-1:0]);
        8'h14:   max_d[1] = $signed(sys_wdata[DW-1:0]);
        default: ;
      endcase
    end
    if (sys_ren) begin
      case (sys_addr[7:0])
        8'h00:   rdata_d = {28'b0, railed_w[1], railed_w[0]};
        8'h04:   rdata_d = {{(16-DW){1'b0}}, center_w[1], {(16-DW){1'b0}}, center_w[0]};
        8'h08:   rdata_d = {{(32-DW){min_q[0][DW-1]}}, min_q[0]};
        8'h0C:   rdata_d = {{(32-DW){max_q[0][DW-1]}}, max_q[0]};
        8'h10:   rdata_d = {{(32-DW){min_q[1][DW-1]}}, min_q[1]};
        8'h14:   rdata_d = {{(32-DW){max_q[1][DW-1]}}, max_q[1]};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q[0] <= MIN_RST;
      min_q[1] <= MIN_RST;
      max_q[0] <= MAX_RST;
      max_q[1] <= MAX_RST;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      min_q[0] <= min_d[0];
      min_q[1] <= min_d[1];
      max_q[0] <= max_d[0];
      max_q[1] <= max_d[1];
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_limit_block.sv
// Scoreboard bench for red_pitaya_limit_block: a driver pushes expected
// per-cycle outputs and bus read data; a monitor pops and compares.
module tb_red_pitaya_limit_block;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [13:0] dat_a_i = '0, dat_b_i = '0;
  logic [13:0] dat_a_o, dat_b_o, center_a_o, center_b_o;
  logic [1:0]  dat_a_railed_o, dat_b_railed_o;
  logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
  logic        sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack;

  red_pitaya_limit_block #(.DW(14)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dat_a_i(dat_a_i), .dat_b_i(dat_b_i),
    .dat_a_o(dat_a_o), .dat_b_o(dat_b_o),
    .dat_a_railed_o(dat_a_railed_o), .dat_b_railed_o(dat_b_railed_o),
    .center_a_o(center_a_o), .center_b_o(center_b_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
  );

  always #4 clk_i = ~clk_i;

  typedef struct {
    int         out_a, out_b, cen_a, cen_b;
    logic [1:0] rail_a, rail_b;
    bit         ack;
  } exp_t;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: what the DUT's registers should hold, as plain integers.
  int         m_min[2], m_max[2], m_out[2], m_cen[2];
  logic [1:0] m_rail[2];

  function automatic int s14(input logic [31:0] w);
    logic [13:0] t;
    t = w[13:0];
    return int'($signed(t));
  endfunction

  function automatic int floor_half(input int s);
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_min[c] = -8192; m_max[c] = 8191; m_out[c] = 0; m_cen[c] = 0; m_rail[c] = 2'b00;
    end
  endtask

  task automatic step(input bit rst, input int a, input int b, input bit wen, input bit ren,
                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    rd_t         r;
    int          ins[2];
    logic [7:0]  ad;
    logic [13:0] ca, cb;
    logic [31:0] av, bv;
    @(negedge clk_i);
    av = a; bv = b;
    rst_i = rst; dat_a_i = av[13:0]; dat_b_i = bv[13:0];
    sys_wen = wen; sys_ren = ren; sys_addr = addr; sys_wdata = wdata;
    ins[0] = s14(av); ins[1] = s14(bv);
    ad = addr[7:0];
    if (rst) begin
      model_reset();
      e.ack = 1'b0;
    end else begin
      if (wen || ren) begin
        r.is_read = ren;
        r.data = '0;
        ca = m_cen[0][13:0];
        cb = m_cen[1][13:0];
        if (ren) begin
          case (ad)
            8'h00: r.data = {28'b0, m_rail[1], m_rail[0]};
            8'h04: r.data = {2'b0, cb, 2'b0, ca};
            8'h08: r.data = m_min[0];
            8'h0C: r.data = m_max[0];
            8'h10: r.data = m_min[1];
            8'h14: r.data = m_max[1];
            default: r.data = '0;
          endcase
        end
        rd_q.push_back(r);
      end
      for (int c = 0; c < 2; c++) begin
        m_rail[c][0] = (ins[c] <= m_min[c]);
        m_rail[c][1] = (ins[c] >= m_max[c]) && ((ins[c] > m_min[c]) || (m_min[c] > m_max[c]));
        if (ins[c] <= m_min[c])      m_out[c] = m_min[c];
        else if (ins[c] >= m_max[c]) m_out[c] = m_max[c];
        else                         m_out[c] = ins[c];
        m_cen[c] = floor_half(m_min[c] + m_max[c]);
      end
      e.ack = wen || ren;
      if (wen) begin
        case (ad)
          8'h08: m_min[0] = s14(wdata);
          8'h0C: m_max[0] = s14(wdata);
          8'h10: m_min[1] = s14(wdata);
          8'h14: m_max[1] = s14(wdata);
          default: ;
        endcase
      end
    end
    e.out_a = m_out[0]; e.out_b = m_out[1];
    e.cen_a = m_cen[0]; e.cen_b = m_cen[1];
    e.rail_a = m_rail[0]; e.rail_b = m_rail[1];
    exp_q.push_back(e);
    $display("[TB] cyc rst=%0b a=%0d b=%0d wen=%0b ren=%0b addr=%h wdata=%h", rst, ins[0], ins[1],
             wen, ren, addr, wdata);
  endtask

  task automatic idle(input int a, input int b);
    step(1'b0, a, b, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input int val);
    step(1'b0, 0, 0, 1'b1, 1'b0, addr, val);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b0, 0, 0, 1'b0, 1'b1, addr, 32'h0);
  endtask

  exp_t mon_e;
  rd_t  mon_r;

  always @(posedge clk_i) begin
    #1;
    chk("sys_err", int'(sys_err), 0);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dat_a_o", int'($signed(dat_a_o)), mon_e.out_a);
      chk("dat_b_o", int'($signed(dat_b_o)), mon_e.out_b);
      chk("railed_a", int'(dat_a_railed_o), int'(mon_e.rail_a));
      chk("railed_b", int'(dat_b_railed_o), int'(mon_e.rail_b));
      chk("center_a", int'($signed(center_a_o)), mon_e.cen_a);
      chk("center_b", int'($signed(center_b_o)), mon_e.cen_b);
      chk("sys_ack", int'(sys_ack), int'(mon_e.ack));
    end
    if (sys_ack) begin
      if (rd_q.size() == 0) begin
        chk("ack_without_request", 1, 0);
      end else begin
        mon_r = rd_q.pop_front();
        if (mon_r.is_read) chk("sys_rdata", int'(sys_rdata), int'(mon_r.data));
      end
    end
  end

  function automatic int pick_val();
    int k;
    logic [13:0] t;
    k = $urandom_range(0, 9);
    case (k)
      0: return -8192;
      1: return 8191;
      2: return 0;
      3: return -1;
      default: begin
        t = 14'($urandom);
        return int'($signed(t));
      end
    endcase
  endfunction

  initial begin
    int a, b, op;
    logic [31:0] addrs[8];
    logic [31:0] ad;
    model_reset();
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h108};

    step(1'b1, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(5000, 0);
    idle(8191, -8192);
    wr(32'h08, 0);
    wr(32'h0C, 4000);
    idle(7000, 0);
    idle(-100, 0);
    idle(2500, 0);
    rd(32'h08);
    rd(32'h0C);
    rd(32'h20);
    idle(7000, 0);
    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h00);
    wr(32'h10, -3000);
    wr(32'h14, -1000);
    idle(2500, 0);
    idle(2500, 0);
    rd(32'h04);
    wr(32'h08, 100);
    wr(32'h0C, -100);
    idle(0, 0);
    rd(32'h00);
    step(1'b0, 7000, 0, 1'b0, 1'b1, 32'h08, 32'h0);
    step(1'b1, 7000, 0, 1'b0, 1'b1, 32'h0C, 32'h0);
    idle(7000, 7000);
    rd(32'h0C);

    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 99);
      a  = ($urandom_range(0, 4) == 0) ? m_min[0] + $urandom_range(0, 2) - 1 : pick_val();
      b  = ($urandom_range(0, 4) == 0) ? m_max[1] + $urandom_range(0, 2) - 1 : pick_val();
      ad = addrs[$urandom_range(0, 7)];
      if (op < 2)       step(1'b1, a, b, op[0], 1'b1, ad, $urandom);
      else if (op < 20) step(1'b0, a, b, 1'b1, 1'b0, ad, {$urandom_range(0, 3) == 0 ? 18'h3FFFF : 18'h0, 14'(pick_val())});
      else if (op < 35) step(1'b0, a, b, 1'b0, 1'b1, ad, 32'h0);
      else if (op < 38) step(1'b0, a, b, 1'b1, 1'b1, ad, $urandom);
      else              idle(a, b);
    end

    idle(0, 0);
    idle(0, 0);
    repeat (3) @(posedge clk_i);
    #2;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
